// File: rtl/arm_mainfsm_ws.sv
`default_nettype none
// ============================================================================
// Module  : arm_mainfsm_ws
// Brief   : Multicycle ARM main control FSM with memory wait states, timeout
//           fault, multicycle multiply and sticky illegal/fault trap.
// Rev     : 1.0
// ============================================================================
module arm_mainfsm_ws #(
    parameter int MUL_LAT     = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op_i,
    input  logic [5:0] Funct_i,
    input  logic       IsMul_i,
    input  logic       MemReady_i,
    output logic       MemReq_o,
    output logic       IRWrite_o,
    output logic       NextPC_o,
    output logic       AdrSrc_o,
    output logic [1:0] ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [1:0] ResultSrc_o,
    output logic       RegW_o,
    output logic       MemW_o,
    output logic       Branch_o,
    output logic       ALUOp_o,
    output logic       MulStart_o,
    output logic       Fault_o,
    output logic       Illegal_o,
    output logic [3:0] State_o
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_MULEXEC  = 4'd10;
    localparam logic [3:0] S_MULWB    = 4'd11;
    localparam logic [3:0] S_UNKNOWN  = 4'd12;
    localparam logic [3:0] S_FAULT    = 4'd13;

    localparam int CNT_MAX = (MUL_LAT > MEM_TIMEOUT) ? MUL_LAT : MEM_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW:0]   C_TMO      = (CW+1)'(MEM_TIMEOUT);
    localparam logic [CW-1:0] C_MUL_LAST = CW'(MUL_LAT - 1);

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fault_q, illegal_q;
    logic          w_is_mem, w_waiting, w_timeout;
    logic [CW:0]   w_cnt_inc;
    logic          unused_funct;

    assign unused_funct = ^Funct_i[4:1];

    // One counter serves both the wait-state timeout and the multiply
    // latency; the states that use them never overlap.
    assign w_is_mem  = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                       (state_q == S_MEMWRITE);
    assign w_waiting = w_is_mem && !MemReady_i;
    assign w_cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
    assign w_timeout = (MEM_TIMEOUT != 0) && w_waiting && (w_cnt_inc >= C_TMO);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (MemReady_i) state_d = S_DECODE;
            S_DECODE: begin
                case (Op_i)
                    2'b00: begin
                        if (Funct_i[5])   state_d = S_EXECUTEI;
                        else if (IsMul_i) state_d = S_MULEXEC;
                        else              state_d = S_EXECUTER;
                    end
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_d = Funct_i[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (MemReady_i) state_d = S_MEMWB;
            S_MEMWRITE: if (MemReady_i) state_d = S_FETCH;
            S_MEMWB, S_ALUWB, S_BRANCH, S_MULWB: state_d = S_FETCH;
            S_EXECUTER, S_EXECUTEI: state_d = S_ALUWB;
            S_MULEXEC:  if (cnt_q == C_MUL_LAST) state_d = S_MULWB;
            S_UNKNOWN, S_FAULT: state_d = state_q;
            default:    state_d = S_UNKNOWN;
        endcase
        if (w_timeout) state_d = S_FAULT;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)
            cnt_d = '0;
        else if (w_waiting || (state_q == S_MULEXEC))
            cnt_d = w_cnt_inc[CW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            fault_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fault_q   <= fault_q | (state_d == S_FAULT);
            illegal_q <= illegal_q | (state_d == S_UNKNOWN);
        end
    end

    always_comb begin
        MemReq_o    = 1'b0;
        IRWrite_o   = 1'b0;
        NextPC_o    = 1'b0;
        AdrSrc_o    = 1'b0;
        ALUSrcA_o   = 2'b00;
        ALUSrcB_o   = 2'b00;
        ResultSrc_o = 2'b00;
        RegW_o      = 1'b0;
        MemW_o      = 1'b0;
        Branch_o    = 1'b0;
        ALUOp_o     = 1'b0;
        MulStart_o  = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemReq_o    = 1'b1;
                IRWrite_o   = MemReady_i && !reset;
                NextPC_o    = MemReady_i && !reset;
                ALUSrcA_o   = 2'b01;
                ALUSrcB_o   = 2'b10;
                ResultSrc_o = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA_o   = 2'b01;
                ALUSrcB_o   = 2'b10;
                ResultSrc_o = 2'b10;
            end
            S_MEMADR:   ALUSrcB_o = 2'b01;
            S_MEMREAD: begin
                MemReq_o = 1'b1;
                AdrSrc_o = 1'b1;
            end
            S_MEMWB: begin
                RegW_o      = 1'b1;
                ResultSrc_o = 2'b01;
            end
            S_MEMWRITE: begin
                MemReq_o = 1'b1;
                AdrSrc_o = 1'b1;
                MemW_o   = 1'b1;
            end
            S_EXECUTER: ALUOp_o = 1'b1;
            S_EXECUTEI: begin
                ALUOp_o   = 1'b1;
                ALUSrcB_o = 2'b01;
            end
            S_ALUWB:    RegW_o = 1'b1;
            S_BRANCH: begin
                Branch_o    = 1'b1;
                ALUSrcA_o   = 2'b10;
                ALUSrcB_o   = 2'b01;
                ResultSrc_o = 2'b10;
            end
            S_MULEXEC:  MulStart_o = (cnt_q == '0);
            S_MULWB: begin
                RegW_o      = 1'b1;
                ResultSrc_o = 2'b11;
            end
            default: ;
        endcase
    end

    assign Fault_o   = fault_q;
    assign Illegal_o = illegal_q;
    assign State_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_arm_mainfsm_ws.sv
`default_nettype none
// ============================================================================
// Module  : tb_arm_mainfsm_ws
// Brief   : Directed scoreboard bench for arm_mainfsm_ws.
// Rev     : 1.0
// ============================================================================
module tb_arm_mainfsm_ws;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IsMul;
    logic       MemReady;
    logic       MemReq, IRWrite, NextPC, AdrSrc, RegW, MemW, Branch, ALUOp;
    logic       MulStart, Fault, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] State;

    typedef struct {
        string       tag;
        logic [20:0] v;
    } exp_t;

    exp_t       sb[$];
    int         n_vec  = 0;
    int         n_fail = 0;
    logic [3:0] prev_s = 4'd0;
    logic [20:0] w_obs;

    always #5 clk = ~clk;

    arm_mainfsm_ws #(.MUL_LAT(4), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .Op_i(Op), .Funct_i(Funct), .IsMul_i(IsMul),
        .MemReady_i(MemReady), .MemReq_o(MemReq), .IRWrite_o(IRWrite),
        .NextPC_o(NextPC), .AdrSrc_o(AdrSrc), .ALUSrcA_o(ALUSrcA),
        .ALUSrcB_o(ALUSrcB), .ResultSrc_o(ResultSrc), .RegW_o(RegW),
        .MemW_o(MemW), .Branch_o(Branch), .ALUOp_o(ALUOp),
        .MulStart_o(MulStart), .Fault_o(Fault), .Illegal_o(Illegal),
        .State_o(State)
    );

    assign w_obs = {State, MemReq, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB,
                    ResultSrc, RegW, MemW, Branch, ALUOp, MulStart, Fault, Illegal};

    // Expected output vector for a state, from the per-state output table.
    function automatic logic [20:0] exp_vec(input logic [3:0] s, input logic mr,
                                            input logic first);
        logic mq = 0, irw = 0, npc = 0, adr = 0, rw = 0, mw = 0, br = 0;
        logic aop = 0, ms = 0, f = 0, il = 0;
        logic [1:0] a = 0, b = 0, r = 0;
        case (s)
            4'd0:  begin mq = 1; irw = mr; npc = mr; a = 2'b01; b = 2'b10; r = 2'b10; end
            4'd1:  begin a = 2'b01; b = 2'b10; r = 2'b10; end
            4'd2:  b = 2'b01;
            4'd3:  begin mq = 1; adr = 1; end
            4'd4:  begin rw = 1; r = 2'b01; end
            4'd5:  begin mq = 1; adr = 1; mw = 1; end
            4'd6:  aop = 1;
            4'd7:  begin aop = 1; b = 2'b01; end
            4'd8:  rw = 1;
            4'd9:  begin br = 1; a = 2'b10; b = 2'b01; r = 2'b10; end
            4'd10: ms = first;
            4'd11: begin rw = 1; r = 2'b11; end
            4'd12: il = 1;
            4'd13: f = 1;
            default: ;
        endcase
        return {s, mq, irw, npc, adr, a, b, r, rw, mw, br, aop, ms, f, il};
    endfunction

    task automatic check();
        exp_t e;
        e = sb.pop_front();
        n_vec++;
        assert (w_obs === e.v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", e.tag, w_obs, e.v);
        end
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [5:0] fn, input logic m);
        Op = op; Funct = fn; IsMul = m;
    endtask

    task automatic step(input logic mr, input logic [3:0] es, input string tag);
        MemReady = mr;
        sb.push_back('{tag, exp_vec(es, mr, (es == 4'd10) && (prev_s != 4'd10))});
        prev_s = es;
        #3;
        check();
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        reset    = 1'b1;
        MemReady = 1'b1;
        #1;
        sb.push_back('{tag, exp_vec(4'd0, 1'b0, 1'b0)});
        check();
        @(negedge clk);
        MemReady = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #1;
        prev_s = 4'd0;
    endtask

    initial begin
        reset = 1'b1; MemReady = 1'b1;
        set_instr(2'b00, 6'b001000, 1'b0);
        #2;
        sb.push_back('{"in_reset", exp_vec(4'd0, 1'b0, 1'b0)});
        check();
        @(negedge clk);
        MemReady = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #1;

        // ADD register
        set_instr(2'b00, 6'b001000, 1'b0);
        step(1, 4'd0, "add_fetch"); step(1, 4'd1, "add_dec");
        step(1, 4'd6, "add_exer");  step(1, 4'd8, "add_aluwb");
        // ADD immediate
        set_instr(2'b00, 6'b101000, 1'b0);
        step(1, 4'd0, "addi_fetch"); step(1, 4'd1, "addi_dec");
        step(1, 4'd7, "addi_exei");  step(1, 4'd8, "addi_aluwb");
        // LDR with three read wait states
        set_instr(2'b01, 6'b011001, 1'b0);
        step(1, 4'd0, "ldr_fetch"); step(1, 4'd1, "ldr_dec"); step(1, 4'd2, "ldr_adr");
        step(0, 4'd3, "ldr_wait1"); step(0, 4'd3, "ldr_wait2"); step(0, 4'd3, "ldr_wait3");
        step(1, 4'd3, "ldr_read");  step(1, 4'd4, "ldr_wb");
        // STR: ready arrives on the cycle the wait limit is reached
        set_instr(2'b01, 6'b011000, 1'b0);
        step(1, 4'd0, "strl_fetch"); step(1, 4'd1, "strl_dec"); step(1, 4'd2, "strl_adr");
        step(0, 4'd5, "strl_wait1"); step(0, 4'd5, "strl_wait2"); step(0, 4'd5, "strl_wait3");
        step(1, 4'd5, "strl_limit_ready");
        // MUL
        set_instr(2'b00, 6'b000000, 1'b1);
        step(1, 4'd0, "mul_fetch"); step(1, 4'd1, "mul_dec");
        for (int i = 0; i < 4; i++) step(1, 4'd10, "mul_exec");
        step(1, 4'd11, "mul_wb");
        // Branch with two fetch wait states
        set_instr(2'b10, 6'b100000, 1'b0);
        step(0, 4'd0, "b_fwait1"); step(0, 4'd0, "b_fwait2"); step(1, 4'd0, "b_fetch");
        step(1, 4'd1, "b_dec");    step(1, 4'd9, "b_branch");
        // STR timing out into FAULT
        set_instr(2'b01, 6'b011000, 1'b0);
        step(1, 4'd0, "strt_fetch"); step(1, 4'd1, "strt_dec"); step(1, 4'd2, "strt_adr");
        for (int i = 0; i < 4; i++) step(0, 4'd5, "strt_wait");
        step(0, 4'd13, "fault1"); step(1, 4'd13, "fault_sticky1"); step(0, 4'd13, "fault_sticky2");
        async_reset_check("reset_from_fault");
        // Undefined opcode
        set_instr(2'b11, 6'b000000, 1'b0);
        step(1, 4'd0, "und_fetch"); step(1, 4'd1, "und_dec");
        for (int i = 0; i < 20; i++) step(1, 4'd12, "und_hold");
        async_reset_check("reset_from_unknown");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
